mips_mem_arbiter: RTL

//  Single-port arbiter for the shared 1024x32 instruction/data memory of the pipelined MIPS32 core.

---
 rtl/mips_mem_arb_pkg.sv | 18 +
 rtl/mips_arb_prio3.sv | 27 ++
 rtl/mips_mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_arb_pkg.sv
// Shared types for the MIPS32 memory arbiter: read-return selector and requester indices.
package mips_mem_arb_pkg;

   // Records which requester owns the read data returning next cycle
   typedef enum logic [1:0] {
      RSEL_NONE = 2'd0,
      RSEL_IF   = 2'd1,
      RSEL_DM   = 2'd2,
      RSEL_DBG  = 2'd3
   } rsel_t;

   // Bit positions of each requester in request/grant vectors
   localparam int unsigned REQ_IF  = 0;
   localparam int unsigned REQ_DM  = 1;
   localparam int unsigned REQ_DBG = 2;
   localparam int unsigned NUM_REQ = 3;

endpackage

// File: rtl/mips_arb_prio3.sv
// Combinational 3-way priority picker: DBG > DM > IF, or DBG > IF > DM when promote is set.
// Output is one-hot (or all zero when nothing requests).
module mips_arb_prio3
   import mips_mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               promote,
   output logic [NUM_REQ-1:0] gnt
);

   // Pick exactly one winner; debug always wins, promotion lifts IF above MEM
   always_comb begin
      gnt = {NUM_REQ{1'b0}};
      if (req[REQ_DBG]) begin
         gnt[REQ_DBG] = 1'b1;
      end else if (promote && req[REQ_IF]) begin
         gnt[REQ_IF] = 1'b1;
      end else if (req[REQ_DM]) begin
         gnt[REQ_DM] = 1'b1;
      end else if (req[REQ_IF]) begin
         gnt[REQ_IF] = 1'b1;
      end else begin
         gnt = {NUM_REQ{1'b0}};
      end
   end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port arbiter for the shared 1024x32 I/D memory of the pipelined MIPS32 core.
// Serves IF fetch, MEM-stage LW/SW and a debug/loader port; routes 1-cycle read data back.
// Optional build macro MEM_ARB_STATS_EN adds saturating grant statistics counters.
module mips_mem_arbiter
   import mips_mem_arb_pkg::*;
#(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CW           = 3
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          cpu_halted,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]   stat_if,
   output logic [31:0]   stat_dm,
   output logic [31:0]   stat_dbg,
   output logic [31:0]   stat_starve
`endif
);

   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic [NUM_REQ-1:0] req_s;
   logic [NUM_REQ-1:0] gnt_s;
   logic               promote_s;
   logic [CW-1:0]      starve_cnt_d, starve_cnt_q;
   rsel_t              rsel_d, rsel_q;

   // Reset masks every request so no grant can leave the block while rst_n is low;
   // a halted core may not fetch
   assign req_s[REQ_IF]  = if_req && !cpu_halted && rst_n;
   assign req_s[REQ_DM]  = dm_req && rst_n;
   assign req_s[REQ_DBG] = dbg_req && rst_n;

   assign promote_s = (starve_cnt_q == LIMIT);

   mips_arb_prio3 u_prio (
      .req     (req_s),
      .promote (promote_s),
      .gnt     (gnt_s)
   );

   assign if_gnt  = gnt_s[REQ_IF];
   assign dm_gnt  = gnt_s[REQ_DM];
   assign dbg_gnt = gnt_s[REQ_DBG];
   assign mem_en  = |gnt_s;

   // Steer the winner's command onto the memory port; idle port drives zeros
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
      if (gnt_s[REQ_DBG]) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else if (gnt_s[REQ_DM]) begin
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (gnt_s[REQ_IF]) begin
         mem_addr  = if_addr;
      end else begin
         mem_we    = 1'b0;
      end
   end

   // Count cycles IF waits while eligible; halt or a grant restarts the count
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (cpu_halted || if_gnt) begin
         starve_cnt_d = {CW{1'b0}};
      end else if (if_req && (starve_cnt_q != LIMIT)) begin
         starve_cnt_d = starve_cnt_q + ONE;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Remember the read winner; a fetch killed by a branch in its grant cycle returns nothing
   always_comb begin
      rsel_d = RSEL_NONE;
      if (gnt_s[REQ_DBG] && !dbg_we) begin
         rsel_d = RSEL_DBG;
      end else if (gnt_s[REQ_DM] && !dm_we) begin
         rsel_d = RSEL_DM;
      end else if (gnt_s[REQ_IF] && !if_flush) begin
         rsel_d = RSEL_IF;
      end else begin
         rsel_d = RSEL_NONE;
      end
   end

   // Arbitration state register with synchronous active-low reset
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         starve_cnt_q <= {CW{1'b0}};
         rsel_q       <= RSEL_NONE;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rsel_q       <= rsel_d;
      end
   end

   // Return path: one rvalid per read, suppressed under reset and for a flushed fetch
   always_comb begin
      if_rvalid  = 1'b0;
      dm_rvalid  = 1'b0;
      dbg_rvalid = 1'b0;
      rdata      = {DW{1'b0}};
      if (rst_n) begin
         if_rvalid  = (rsel_q == RSEL_IF) && !if_flush;
         dm_rvalid  = (rsel_q == RSEL_DM);
         dbg_rvalid = (rsel_q == RSEL_DBG);
         rdata      = mem_rdata;
      end else begin
         rdata      = {DW{1'b0}};
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_d, stat_if_q;
   logic [31:0] stat_dm_d, stat_dm_q;
   logic [31:0] stat_dbg_d, stat_dbg_q;
   logic [31:0] stat_starve_d, stat_starve_q;

   // Saturating grant counters; promoted IF grants counted separately
   always_comb begin
      stat_if_d     = stat_if_q;
      stat_dm_d     = stat_dm_q;
      stat_dbg_d    = stat_dbg_q;
      stat_starve_d = stat_starve_q;
      if (if_gnt && (stat_if_q != 32'hFFFF_FFFF)) begin
         stat_if_d = stat_if_q + 32'd1;
      end else begin
         stat_if_d = stat_if_q;
      end
      if (dm_gnt && (stat_dm_q != 32'hFFFF_FFFF)) begin
         stat_dm_d = stat_dm_q + 32'd1;
      end else begin
         stat_dm_d = stat_dm_q;
      end
      if (dbg_gnt && (stat_dbg_q != 32'hFFFF_FFFF)) begin
         stat_dbg_d = stat_dbg_q + 32'd1;
      end else begin
         stat_dbg_d = stat_dbg_q;
      end
      if (if_gnt && promote_s && (stat_starve_q != 32'hFFFF_FFFF)) begin
         stat_starve_d = stat_starve_q + 32'd1;
      end else begin
         stat_starve_d = stat_starve_q;
      end
   end

   // Statistics registers, cleared by reset
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         stat_if_q     <= 32'd0;
         stat_dm_q     <= 32'd0;
         stat_dbg_q    <= 32'd0;
         stat_starve_q <= 32'd0;
      end else begin
         stat_if_q     <= stat_if_d;
         stat_dm_q     <= stat_dm_d;
         stat_dbg_q    <= stat_dbg_d;
         stat_starve_q <= stat_starve_d;
      end
   end

   assign stat_if     = stat_if_q;
   assign stat_dm     = stat_dm_q;
   assign stat_dbg    = stat_dbg_q;
   assign stat_starve = stat_starve_q;
`endif

endmodule
